fetch_ctrl: RTL and testbench

Fetch sequencer for the RV32 fetch stage. Owns the program counter, drives a variable-latency instruction-memory request/acknowledge port with one outstanding request, and buffers up to two fetched instructions for decode. Accepts branch/jump redirects (`PCSrc`/`PCTarget`) from execute, flushes the buffer and discards any in-flight response. Sits between instruction memory and the decode pipeline register.

---
 rtl/fetch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32 fetch sequencer with the PC, a one-outstanding imem port and a 2-entry decode buffer.
// Defining FETCH_MISALIGN_TRAP_EN adds the misalign output and a terminal HALT state.
module fetch_ctrl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrc,
  input  logic [DATA_WIDTH-1:0] PCTarget,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] PCPlus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  misalign
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {BOOT, RUN, DROP, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, DROP} state_t;
`endif

  state_t                state, state_d;
  logic [DATA_WIDTH-1:0] fetch_pc, fetch_pc_d;
  logic [DATA_WIDTH-1:0] target, target_d;
  logic [DATA_WIDTH-1:0] tgt;
  logic [1:0]            count, count_d;
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [DATA_WIDTH-1:0] buf_pc   [2];
  logic                  push, pop, hs;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  misalign_d, halt_pend, halt_pend_d, trap;
`endif

  // Outputs depend only on registered state, never on inputs.
  assign imem_req    = (state == RUN && count != 2'd2) || state == DROP;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0);
  assign instr       = buf_data[0];
  assign instr_pc    = buf_pc[0];
  assign PCPlus4     = buf_pc[0] + DATA_WIDTH'(4);
  assign hs          = imem_req & imem_ack;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt  = PCTarget;
  assign trap = PCSrc && (tgt[1:0] != 2'b00) && (state == RUN || state == DROP) && !halt_pend;
`else
  assign tgt  = PCTarget & ~DATA_WIDTH'(3);
`endif

  always_comb begin
    state_d    = state;
    fetch_pc_d = fetch_pc;
    target_d   = target;
    count_d    = count;
    push       = 1'b0;
    pop        = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d  = misalign;
    halt_pend_d = halt_pend;
`endif
    case (state)
      BOOT: state_d = RUN;
      RUN: begin
        if (PCSrc) begin
          count_d = '0;
          if (imem_req && !imem_ack) begin
            target_d = tgt;
            state_d  = DROP;
          end else begin
            fetch_pc_d = tgt;
          end
        end else begin
          push = hs;
          pop  = instr_valid && !stall;
          if (push) fetch_pc_d = fetch_pc + DATA_WIDTH'(4);
          if (push && !pop)      count_d = count + 2'd1;
          else if (pop && !push) count_d = count - 2'd1;
        end
      end
      DROP: begin
        count_d = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (halt_pend) begin
          if (hs) state_d = HALT;
        end else
`endif
        if (PCSrc && hs) begin
          fetch_pc_d = tgt;
          state_d    = RUN;
        end else if (PCSrc) begin
          target_d = tgt;
        end else if (hs) begin
          fetch_pc_d = target;
          state_d    = RUN;
        end
      end
      default: ;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    // A misaligned redirect overrides the normal redirect; an in-flight request is drained first.
    if (trap) begin
      count_d    = '0;
      misalign_d = 1'b1;
      fetch_pc_d = fetch_pc;
      target_d   = target;
      if (imem_req && !imem_ack) begin
        state_d     = DROP;
        halt_pend_d = 1'b1;
      end else begin
        state_d = HALT;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      target      <= RESET_PC;
      count       <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      target   <= target_d;
      count    <= count_d;
      // Entry 0 is the head; a push lands in the first slot that is free after any pop.
      if (push && (pop || count == 2'd0)) begin
        buf_data[0] <= imem_rdata;
        buf_pc[0]   <= fetch_pc;
      end else if (push) begin
        buf_data[1] <= imem_rdata;
        buf_pc[1]   <= fetch_pc;
      end else if (pop) begin
        buf_data[0] <= buf_data[1];
        buf_pc[0]   <= buf_pc[1];
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign  <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      misalign  <= misalign_d;
      halt_pend <= halt_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; memory responder acks in the lat-th cycle of a request.
module tb_fetch_ctrl;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCSrc = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] PCTarget = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, PCPlus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int   tests = 0;
  int   fails = 0;
  int   lat = 1;
  int   wcnt = 0;
  logic last_hs = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .PCSrc(PCSrc), .PCTarget(PCTarget), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .PCPlus4(PCPlus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  // Instruction word for address a is a ^ KEY.
  always @(negedge clk) begin
    if (rst || !imem_req) wcnt = 0;
    else if (last_hs)     wcnt = 1;
    else                  wcnt = wcnt + 1;
    imem_ack   = !rst && imem_req && (wcnt >= lat);
    imem_rdata = imem_addr ^ KEY;
    last_hs    = imem_ack;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; PCSrc = 1'b0; stall = 1'b0; lat = 1; PCTarget = '0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; PCSrc = 1'b0; stall = 1'b0; lat = 1;
    tick; tick;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", imem_req); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 0", instr); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", instr_pc); end
    tests++; if (PCPlus4 !== 32'h4) begin fails++; $display("FAIL rst_pcplus4 got %h exp 4", PCPlus4); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign got %b exp 0", misalign); end
`endif
    rst = 1'b0;
    tick;
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL boot_req got %b exp 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL boot_addr got %h exp 0", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL boot_valid got %b exp 0", instr_valid); end
  endtask

  task automatic test_zero_wait;
    logic [31:0] exp_pc;
    for (int k = 1; k <= 4; k++) begin
      tick;
      exp_pc = 32'(4 * (k - 1));
      tests++; if (imem_addr !== 32'(4 * k)) begin fails++; $display("FAIL zw_addr[%0d] got %h exp %h", k, imem_addr, 32'(4 * k)); end
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL zw_valid[%0d] got %b exp 1", k, instr_valid); end
      tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL zw_pc[%0d] got %h exp %h", k, instr_pc, exp_pc); end
      tests++; if (instr !== (exp_pc ^ KEY)) begin fails++; $display("FAIL zw_instr[%0d] got %h exp %h", k, instr, exp_pc ^ KEY); end
      tests++; if (PCPlus4 !== exp_pc + 32'd4) begin fails++; $display("FAIL zw_pcplus4[%0d] got %h exp %h", k, PCPlus4, exp_pc + 32'd4); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] exp_pc;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d] got %b exp 0", k, imem_req); end
      tests++; if (instr_pc !== 32'd12) begin fails++; $display("FAIL stall_pc[%0d] got %h exp c", k, instr_pc); end
      tests++; if (instr !== (32'd12 ^ KEY)) begin fails++; $display("FAIL stall_instr[%0d] got %h exp %h", k, instr, 32'd12 ^ KEY); end
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      exp_pc = 32'(16 + 4 * k);
      tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL unstall_valid[%0d] got %b exp 1", k, instr_valid); end
      tests++; if (instr_pc !== exp_pc) begin fails++; $display("FAIL unstall_pc[%0d] got %h exp %h", k, instr_pc, exp_pc); end
      tests++; if (instr !== (exp_pc ^ KEY)) begin fails++; $display("FAIL unstall_instr[%0d] got %h exp %h", k, instr, exp_pc ^ KEY); end
    end
  endtask

  task automatic test_drop;
    do_reset;
    lat = 3;
    tick; tick;
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL drop_pre_addr got %h exp 0", imem_addr); end
    PCSrc = 1'b1; PCTarget = 32'h100;
    tick;
    PCSrc = 1'b0;
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL drop_req got %b exp 1", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL drop_hold_addr got %h exp 0", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL drop_valid got %b exp 0", instr_valid); end
    tick;
    tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL drop_new_addr got %h exp 100", imem_addr); end
    for (int k = 0; k < 2; k++) begin
      tick;
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL drop_wait_valid[%0d] got %b exp 0", k, instr_valid); end
    end
    tick;
    tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL drop_arrive_valid got %b exp 1", instr_valid); end
    tests++; if (instr_pc !== 32'h100) begin fails++; $display("FAIL drop_arrive_pc got %h exp 100", instr_pc); end
    tests++; if (instr !== (32'h100 ^ KEY)) begin fails++; $display("FAIL drop_arrive_instr got %h exp %h", instr, 32'h100 ^ KEY); end
    tests++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL drop_next_addr got %h exp 104", imem_addr); end
  endtask

  task automatic test_redirect_ack;
    do_reset;
    tick; tick; tick;
    tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL ra_pre_addr got %h exp 8", imem_addr); end
    PCSrc = 1'b1; PCTarget = 32'h40;
    tick;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL ra_valid got %b exp 0", instr_valid); end
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL ra_addr got %h exp 40", imem_addr); end
    lat = 3; PCTarget = 32'h200;
    tick;
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL ra_drop_addr got %h exp 40", imem_addr); end
    PCTarget = 32'h80;
    tick;
    PCSrc = 1'b0;
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL ra_drop2_addr got %h exp 40", imem_addr); end
    tick;
    tests++; if (imem_addr !== 32'h80) begin fails++; $display("FAIL ra_retarget_addr got %h exp 80", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL ra_retarget_valid got %b exp 0", instr_valid); end
    tick; tick; tick;
    tests++; if (instr_pc !== 32'h80 || instr_valid !== 1'b1) begin fails++; $display("FAIL ra_arrive got pc %h v %b exp 80 1", instr_pc, instr_valid); end
  endtask

  task automatic test_wrap_and_async_reset;
    do_reset;
    tick;
    PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    tick;
    PCSrc = 1'b0;
    tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_valid got %b exp 0", instr_valid); end
    tick;
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_next_addr got %h exp 0", imem_addr); end
    tests++; if (instr_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc got %h exp fffffffc", instr_pc); end
    tests++; if (PCPlus4 !== 32'h0) begin fails++; $display("FAIL wrap_pcplus4 got %h exp 0", PCPlus4); end
    tick;
    tests++; if (instr_pc !== 32'h0 || imem_addr !== 32'h4) begin fails++; $display("FAIL wrap_after got pc %h addr %h exp 0 4", instr_pc, imem_addr); end
    lat = 5; PCSrc = 1'b1; PCTarget = 32'h300;
    tick;
    PCSrc = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin fails++; $display("FAIL wrap_drop got req %b addr %h exp 1 4", imem_req, imem_addr); end
    #2 rst = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL arst_req got %b exp 0", imem_req); end
    tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL arst_addr got %h exp 0", imem_addr); end
    tests++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin fails++; $display("FAIL arst_instr got v %b i %h pc %h exp 0 0 0", instr_valid, instr, instr_pc); end
    tests++; if (PCPlus4 !== 32'h4) begin fails++; $display("FAIL arst_pcplus4 got %h exp 4", PCPlus4); end
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign;
    do_reset;
    tick; tick;
    PCSrc = 1'b1; PCTarget = 32'h102;
    tick;
    PCTarget = 32'h200;
    for (int k = 0; k < 3; k++) begin
      tests++; if (misalign !== 1'b1) begin fails++; $display("FAIL mis_flag[%0d] got %b exp 1", k, misalign); end
      tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL mis_req[%0d] got %b exp 0", k, imem_req); end
      tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL mis_valid[%0d] got %b exp 0", k, instr_valid); end
      tick;
    end
    PCSrc = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (misalign !== 1'b0) begin fails++; $display("FAIL mis_rst got %b exp 0", misalign); end
  endtask
`endif

  initial begin
    test_reset;
    test_zero_wait;
    test_stall;
    test_drop;
    test_redirect_ack;
    test_wrap_and_async_reset;
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
